// File: rtl/lstm_wt_pkg.sv
// Shared definitions for the LSTM weight tile buffer and its read-side sequencer.
package lstm_wt_pkg;

    localparam int WT_DATA_WIDTH = 32;
    localparam int WT_ADDR_WIDTH = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FULL = 2'd1,
        STREAM    = 2'd2,
        DRAIN     = 2'd3
    } rd_state_e;

    function automatic int tile_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/weight_tile_reader_if.sv
// Valid/ready weight word stream from the tile reader to the MAC array.
interface weight_tile_reader_if
    import lstm_wt_pkg::*;
#(
    parameter int DATA_WIDTH = WT_DATA_WIDTH
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/weight_stream_out_reg.sv
// One-entry valid/ready holding register; load_ok tells the producer a word may be loaded this cycle.
module weight_stream_out_reg
    import lstm_wt_pkg::*;
#(
    parameter int DATA_WIDTH = WT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ok,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last,
    input  logic                  ready
);

    // Space exists when empty or when the held word leaves this cycle.
    assign load_ok = !valid || ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/weight_tile_reader.sv
// Read-side sequencer: streams tiles_req full weight tiles, each word once in address order.
// Optional WEIGHT_TILE_READER_CHECKSUM_EN adds a per-tile XOR checksum output.
module weight_tile_reader
    import lstm_wt_pkg::*;
#(
    parameter int DATA_WIDTH = WT_DATA_WIDTH,
    parameter int ADDR_WIDTH = WT_ADDR_WIDTH,
    parameter int TILE_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [TILE_CNT_W-1:0] tiles_req,
    input  logic                  tile_full,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    weight_tile_reader_if.master  m,
    output logic                  busy,
    output logic [TILE_CNT_W-1:0] tiles_done,
    output logic                  all_done
`ifdef WEIGHT_TILE_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] tile_csum,
    output logic                  tile_csum_valid
`endif
);

    localparam int TILE_DEPTH = tile_depth(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TILE_DEPTH - 1);
    localparam logic [TILE_CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [TILE_CNT_W-1:0] sat_inc(input logic [TILE_CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    rd_state_e             state;
    logic [TILE_CNT_W-1:0] req_q;
    logic [TILE_CNT_W-1:0] done_next;
    logic                  load_ok;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;
    logic                  last_accept;

    assign rd_en       = (state == STREAM) && load_ok;
    assign last_accept = (state == DRAIN) && out_valid && m.ready && out_last;
    assign done_next   = sat_inc(tiles_done);

    assign m.valid = out_valid;
    assign m.data  = out_data;
    assign m.last  = out_last;

    weight_stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (rd_en),
        .load_data (rd_data),
        .load_last (rd_addr == LAST_ADDR),
        .load_ok   (load_ok),
        .valid     (out_valid),
        .data      (out_data),
        .last      (out_last),
        .ready     (m.ready)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_addr    <= '0;
            req_q      <= '0;
            tiles_done <= '0;
            all_done   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            all_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (tiles_req != '0) begin
                            req_q      <= tiles_req;
                            tiles_done <= '0;
                            busy       <= 1'b1;
                            state      <= WAIT_FULL;
                        end else begin
                            all_done <= 1'b1;
                        end
                    end
                end
                WAIT_FULL: begin
                    if (tile_full) begin
                        rd_addr <= '0;
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    // tile_full may drop here (buffer release); the tile is still finished.
                    if (rd_en) begin
                        rd_addr <= rd_addr + 1'b1;
                        if (rd_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (last_accept) begin
                        tiles_done <= done_next;
                        if (done_next == req_q) begin
                            all_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            state <= WAIT_FULL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WEIGHT_TILE_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csum_acc        <= '0;
            tile_csum       <= '0;
            tile_csum_valid <= 1'b0;
        end else begin
            tile_csum_valid <= 1'b0;
            if (state == WAIT_FULL && tile_full) begin
                csum_acc <= '0;
            end else if (rd_en) begin
                csum_acc <= csum_acc ^ rd_data;
            end
            // All reads are done before DRAIN, so the accumulator is final here.
            if (last_accept) begin
                tile_csum       <= csum_acc;
                tile_csum_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_weight_tile_reader.sv
// Scoreboard bench for weight_tile_reader with a behavioural tile buffer model.
module tb_weight_tile_reader;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tiles_req = '0;
    logic        tile_full;
    logic [31:0] rd_data;
    logic        rd_en;
    logic [1:0]  rd_addr;
    logic        busy;
    logic [7:0]  tiles_done;
    logic        all_done;
`ifdef WEIGHT_TILE_READER_CHECKSUM_EN
    logic [31:0] tile_csum;
    logic        tile_csum_valid;
    int          csum_pulses = 0;
    logic [31:0] csum_seen = '0;
`endif

    weight_tile_reader_if #(.DATA_WIDTH(32)) bus ();

    weight_tile_reader #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (2),
        .TILE_CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .tiles_req  (tiles_req),
        .tile_full  (tile_full),
        .rd_data    (rd_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .m          (bus.master),
        .busy       (busy),
        .tiles_done (tiles_done),
        .all_done   (all_done)
`ifdef WEIGHT_TILE_READER_CHECKSUM_EN
        ,
        .tile_csum       (tile_csum),
        .tile_csum_valid (tile_csum_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tile buffer model: combinational read, done cleared on the last read edge.
    logic [31:0] mem [4];
    logic        fill_req = 1'b0;
    logic [1:0]  buf_cnt;
    assign rd_data = mem[rd_addr];

    always @(posedge clk) begin
        if (!rst_n) begin
            tile_full <= 1'b0;
            buf_cnt   <= '0;
        end else begin
            if (rd_en) begin
                buf_cnt <= buf_cnt + 2'd1;
                if (buf_cnt == 2'd3) tile_full <= 1'b0;
            end
            if (fill_req) tile_full <= 1'b1;
        end
    end

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];
    int   rd_cyc[$];
    int   rd_adr[$];
    int   acc_cyc[$];
    int   rd_total = 0;
    int   acc_n = 0;
    int   done_cnt = 0;
    bit   bp_mode = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Consumer ready: always 1, or the repeating 1,0,0,1,0,1 pattern.
    initial begin
        bit pat [6];
        int pidx;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        pidx = 0;
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                bus.ready = pat[pidx];
                pidx = (pidx + 1) % 6;
            end else begin
                bus.ready = 1'b1;
            end
        end
    end

    // Output monitor on the falling edge.
    initial begin
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        exp_t        e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (rd_en) begin
                    rd_adr.push_back(int'(rd_addr));
                    rd_cyc.push_back(cyc);
                    rd_total++;
                end
                if (prev_stall) begin
                    check("hold_data", 64'(bus.data), 64'(prev_data));
                    check("hold_last", 64'(bus.last), 64'(prev_last));
                end
                if (bus.valid && !bus.ready) check("rd_en_in_stall", 64'(rd_en), 64'(0));
                if (bus.valid && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_word", 64'(1), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", 64'(bus.data), 64'(e.data));
                        check("m_last", 64'(bus.last), 64'(e.last));
                    end
                    acc_n++;
                    acc_cyc.push_back(cyc);
                end
                if (all_done) done_cnt++;
`ifdef WEIGHT_TILE_READER_CHECKSUM_EN
                if (tile_csum_valid) begin
                    csum_pulses++;
                    csum_seen = tile_csum;
                end
`endif
                prev_stall = bus.valid && !bus.ready;
                prev_data  = bus.data;
                prev_last  = bus.last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] n);
        tiles_req = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic fill_tile(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
        exp_q.push_back('{data: w0, last: 1'b0});
        exp_q.push_back('{data: w1, last: 1'b0});
        exp_q.push_back('{data: w2, last: 1'b0});
        exp_q.push_back('{data: w3, last: 1'b1});
        fill_req = 1'b1;
        cycle();
        fill_req = 1'b0;
    endtask

    task automatic wait_done(input int base, input string tag);
        for (int i = 0; i < 200 && done_cnt <= base; i++) cycle();
        check(tag, 64'(done_cnt > base), 64'(1));
    endtask

    task automatic wait_tiles(input int target, input string tag);
        for (int i = 0; i < 200 && int'(tiles_done) < target; i++) cycle();
        check(tag, 64'(tiles_done), 64'(target));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rd_en"},    64'(rd_en),      64'(0));
        check({tag, "_rd_addr"},  64'(rd_addr),    64'(0));
        check({tag, "_m_valid"},  64'(bus.valid),  64'(0));
        check({tag, "_m_data"},   64'(bus.data),   64'(0));
        check({tag, "_m_last"},   64'(bus.last),   64'(0));
        check({tag, "_busy"},     64'(busy),       64'(0));
        check({tag, "_tiles"},    64'(tiles_done), 64'(0));
        check({tag, "_all_done"}, 64'(all_done),   64'(0));
    endtask

    initial begin
        int base, rbase;
        mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        check_idle_outputs("reset");

        // Basic tile with continuous ready.
        rd_cyc.delete(); rd_adr.delete(); acc_cyc.delete();
        base = done_cnt; rbase = rd_total;
        pulse_start(8'd1);
        check("busy_after_start", 64'(busy), 64'(1));
        fill_tile(32'h11, 32'h22, 32'h33, 32'h44);
        wait_done(base, "basic_done_timeout");
        cycle();
        check("basic_reads", 64'(rd_total - rbase), 64'(4));
        for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
            check("basic_rd_addr", 64'(rd_adr[i]), 64'(i));
            check("basic_rd_consec", 64'(rd_cyc[i] - rd_cyc[0]), 64'(i));
        end
        if (acc_cyc.size() == 4 && rd_cyc.size() == 4) begin
            check("first_valid_latency", 64'(acc_cyc[0] - rd_cyc[0]), 64'(1));
            check("basic_acc_consec", 64'(acc_cyc[3] - acc_cyc[0]), 64'(3));
        end else begin
            check("basic_word_count", 64'(acc_cyc.size()), 64'(4));
        end
        check("basic_tiles_done", 64'(tiles_done), 64'(1));
        check("basic_busy_fall", 64'(busy), 64'(0));
        check("basic_done_once", 64'(done_cnt - base), 64'(1));
        check("basic_queue_empty", 64'(exp_q.size()), 64'(0));

        // Back-pressure.
        bp_mode = 1'b1;
        base = done_cnt; rbase = rd_total;
        pulse_start(8'd1);
        fill_tile(32'h11, 32'h22, 32'h33, 32'h44);
        wait_done(base, "bp_done_timeout");
        bp_mode = 1'b0;
        cycle();
        check("bp_reads", 64'(rd_total - rbase), 64'(4));
        check("bp_queue_empty", 64'(exp_q.size()), 64'(0));

        // Three tiles, each filled only after the previous one drains.
        base = done_cnt;
        pulse_start(8'd3);
        for (int t = 0; t < 3; t++) begin
            fill_tile(32'hA000 + 32'(t * 16), 32'hA001 + 32'(t * 16),
                      32'hA002 + 32'(t * 16), 32'hA003 + 32'(t * 16));
            wait_tiles(t + 1, "multi_tiles_done");
            if (t < 2) begin
                cycle();
                cycle();
                check("multi_wait_busy", 64'(busy), 64'(1));
                check("multi_wait_rd_en", 64'(rd_en), 64'(0));
                check("multi_no_early_done", 64'(done_cnt - base), 64'(0));
            end
        end
        wait_done(base, "multi_done_timeout");
        check("multi_done_once", 64'(done_cnt - base), 64'(1));
        check("multi_queue_empty", 64'(exp_q.size()), 64'(0));

        // Zero-tile request.
        rbase = rd_total;
        pulse_start(8'd0);
        check("zero_all_done", 64'(all_done), 64'(1));
        check("zero_busy", 64'(busy), 64'(0));
        check("zero_rd_en", 64'(rd_en), 64'(0));
        cycle();
        check("zero_done_pulse", 64'(all_done), 64'(0));
        check("zero_no_reads", 64'(rd_total - rbase), 64'(0));

        // start while streaming must not replace the latched request of 2.
        base = done_cnt; rbase = rd_total;
        pulse_start(8'd2);
        fill_tile(32'hB0, 32'hB1, 32'hB2, 32'hB3);
        for (int i = 0; i < 100 && rd_total == rbase; i++) @(negedge clk);
        cycle();
        pulse_start(8'd5);
        wait_tiles(1, "ign_first_tile");
        fill_tile(32'hC0, 32'hC1, 32'hC2, 32'hC3);
        wait_done(base, "ign_done_timeout");
        check("ign_tiles_done", 64'(tiles_done), 64'(2));

        // Reset after the second word of a tile.
        base = acc_n;
        pulse_start(8'd1);
        fill_tile(32'hD0, 32'hD1, 32'hD2, 32'hD3);
        for (int i = 0; i < 100 && acc_n < base + 2; i++) @(negedge clk);
        check("rst_two_words", 64'(acc_n - base), 64'(2));
        cycle();
        rst_n = 1'b0;
        exp_q.delete();
        cycle();
        rst_n = 1'b1;
        check_idle_outputs("midrst");
        rd_adr.delete();
        base = done_cnt;
        pulse_start(8'd1);
        fill_tile(32'hE0, 32'hE1, 32'hE2, 32'hE3);
        wait_done(base, "rst_restart_timeout");
        check("rst_restart_addr0", 64'(rd_adr.size() > 0 ? rd_adr[0] : -1), 64'(0));
        check("rst_queue_empty", 64'(exp_q.size()), 64'(0));

`ifdef WEIGHT_TILE_READER_CHECKSUM_EN
        base = done_cnt;
        csum_pulses = 0;
        csum_seen = 32'hFFFF_FFFF;
        pulse_start(8'd1);
        fill_tile(32'hF0, 32'h0F, 32'hAA, 32'h55);
        wait_done(base, "csum_done_timeout");
        check("csum_value", 64'(csum_seen), 64'(0));
        check("csum_pulses", 64'(csum_pulses), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got time %0t expected < 200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
